full_adder_bist: RTL and testbench
==================================

// Module: full_adder_bist
// PURPOSE
//  Synthesizable exhaustive stimulus/response engine for a 1-bit full adder.
//  Drives all 8 {A,B,Cin} vectors into a DUT, samples Sum/Cout, compares them against a golden model,
//  and counts mismatches. Sits beside the full_adder instance in hardware self-test builds.
//  It is the checking end of the adder interface: it drives A/B/Cin and consumes Sum/Cout.
// PARAMETERS
//  SETTLE_CYCLES  1  cycles each vector is held before sampling; legal range >=1
//  PASSES         1  number of complete 8-vector sweeps per run; legal range >=1
//  ERR_W          8  width of the mismatch counter
// PORTS
//  clk             in   1      rising-edge clock
//  rst             in   1      synchronous, active-high reset
//  start           in   1      request a run; sampled only in IDLE
//  dut_a           out  1      DUT operand A (registered)
//  dut_b           out  1      DUT operand B (registered)
//  dut_cin         out  1      DUT carry-in (registered)
//  dut_sum         in   1      DUT sum response
//  dut_cout        in   1      DUT carry-out response
//  busy            out  1      high from start acceptance until done
//  done            out  1      one-cycle pulse at end of run
//  pass            out  1      err_count==0; valid from done until next start acceptance
//  err_count       out  ERR_W  mismatches this run; saturates at all-ones
//  first_fail_vld  out  1      at least one mismatch captured this run
//  first_fail_vec  out  3      {A,B,Cin} of the first mismatch
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0 (dut_a/b/cin=0, busy=0, done=0, pass=0, err_count=0,
//    first_fail_vld=0, first_fail_vec=0). Reset mid-run aborts on that edge; no done pulse.
//  - FSM IDLE -> APPLY -> CHECK -> (APPLY | FINISH) -> IDLE.
//  - IDLE: if start=1 at edge, go to APPLY with vec=0, pass_cnt=0. Clear err_count, pass,
//    first_fail_*. Drive dut_{a,b,cin}={vec}=3'b000 and set busy=1.
//  - APPLY: hold the vector for SETTLE_CYCLES cycles (settle counter), then go to CHECK.
//  - CHECK (1 cycle): exp_sum=a^b^cin; exp_cout=ab|ac|bc.
//    - On mismatch of either bit: err_count+=1 (saturating). If first_fail_vld=0, capture vec
//      and set first_fail_vld.
//    - If vec=7 and pass_cnt=PASSES-1, go to FINISH. Otherwise vec+=1 (wrapping 7->0 and
//      incrementing pass_cnt at the wrap), drive the new vector, and go to APPLY.
//  - FINISH (1 cycle): done=1, busy=0, pass=(err_count==0 incl. the final CHECK); next state IDLE.
//    pass, err_count and first_fail_* hold until the next accepted start.
//  - Run length, start edge to done-high: 8*PASSES*(SETTLE_CYCLES+1)+1 cycles.
//    Defaults give 17.
//  - start while busy: ignored. start high in the FINISH cycle: ignored. start high in IDLE on
//    the cycle after done: accepted.
//  - dut_* outputs keep the last vector (3'b111) after a run; they return to 0 only on reset.
// CONFIGURATION
//  FA_BIST_FAULT_INJECT_EN defined:
//    - Adds input port inject (1 bit), sampled at start acceptance and held for the run.
//    - When latched high, expected Sum is inverted for vector 3'b101 only. A correct DUT then
//      yields err_count=PASSES, pass=0, first_fail_vec=3'b101. This self-tests the checker.
//  Macro undefined:
//    - No inject port and no inversion logic. Behaviour is exactly as in BEHAVIOUR.
// STRUCTURE
//  - Package fa_bist_pkg:
//    - state enum {IDLE,APPLY,CHECK,FINISH}.
//    - VEC_W=3, NUM_VEC=8, LAST_VEC=3'b111.
//    - Function fa_expected(vec) returning {cout,sum}.
//  - Sub-module full_adder_ref: purely combinational golden model (vec -> exp_sum, exp_cout),
//    instantiated once. CHECK compares against its outputs.
// TESTING
//  1 Good DUT, defaults, start pulse -> done at cycle 17 after start; pass=1, err_count=0,
//    first_fail_vld=0. Vectors 000..111 observed in order, each held 1 cycle before its check.
//  2 DUT with Cout stuck-at-0 -> err_count=4 (vectors 011,101,110,111), pass=0,
//    first_fail_vec=3'b011.
//  3 PASSES=3, SETTLE_CYCLES=2, Sum stuck-at-1 -> done 73 cycles after start; err_count=12;
//    first_fail_vec=3'b000.
//  4 Assert rst while vec=4 in APPLY -> next edge: busy=0, done never pulses, all outputs 0.
//    Fresh start then completes normally.
//  5 start held high continuously -> back-to-back runs; second run accepted the cycle after
//    done. The start pulse during busy is ignored and causes no restart.
//  6 ERR_W=2, PASSES=2, Sum inverted DUT -> err_count saturates at 3, pass=0.
//    With FA_BIST_FAULT_INJECT_EN, good DUT, inject=1 -> err_count=PASSES, first_fail_vec=3'b101.

Source files
------------

// File: rtl/fa_bist_pkg.sv
// Shared types, constants and golden full-adder function for the full-adder BIST engine.
package fa_bist_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    CHECK  = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam int VEC_W = 3;
  localparam int NUM_VEC = 8;
  localparam logic [VEC_W-1:0] LAST_VEC = 3'b111;

  // vec is {a,b,cin}; result is {cout,sum}
  function automatic logic [1:0] fa_expected(input logic [VEC_W-1:0] vec);
    logic [1:0] r;
    r[0] = vec[2] ^ vec[1] ^ vec[0];
    r[1] = (vec[2] & vec[1]) | (vec[2] & vec[0]) | (vec[1] & vec[0]);
    return r;
  endfunction

endpackage

// File: rtl/full_adder_bist_if.sv
// Adder-under-test connection: the BIST (master) drives operands, the adder (slave) answers.
interface full_adder_bist_if;
  logic a;
  logic b;
  logic cin;
  logic sum;
  logic cout;

  modport master (output a, output b, output cin, input sum, input cout);
  modport slave  (input a, input b, input cin, output sum, output cout);
endinterface

// File: rtl/full_adder_bist_ref.sv
// Combinational golden full adder used by the BIST checker.
module full_adder_ref
  import fa_bist_pkg::*;
(
  input  logic [VEC_W-1:0] vec,
  output logic             exp_sum,
  output logic             exp_cout
);
  logic [1:0] r;

  assign r        = fa_expected(vec);
  assign exp_sum  = r[0];
  assign exp_cout = r[1];
endmodule

// File: rtl/full_adder_bist.sv
// Exhaustive stimulus/response BIST for a 1-bit full adder.
// Optional macro FA_BIST_FAULT_INJECT_EN adds the inject port that corrupts expected Sum for 3'b101.
module full_adder_bist
  import fa_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int PASSES        = 1,
  parameter int ERR_W         = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
`ifdef FA_BIST_FAULT_INJECT_EN
  input  logic               inject,
`endif
  full_adder_bist_if.master  dut,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ERR_W-1:0]   err_count,
  output logic               first_fail_vld,
  output logic [VEC_W-1:0]   first_fail_vec,
  output state_t             dbg_state
);

  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int PAS_W = (PASSES > 1) ? $clog2(PASSES) : 1;

  state_t            state_q, state_d;
  logic [VEC_W-1:0]  vec_q;
  logic [SET_W-1:0]  settle_q;
  logic [PAS_W-1:0]  pass_cnt_q;
  logic              settle_done, last_vec;
  logic              exp_sum, exp_cout, exp_sum_eff, mismatch;
  logic              accept, do_settle, do_check, do_finish;

  assign settle_done = (settle_q == SET_W'(SETTLE_CYCLES - 1));
  assign last_vec    = (vec_q == LAST_VEC) && (pass_cnt_q == PAS_W'(PASSES - 1));

  full_adder_ref u_ref (
    .vec      (vec_q),
    .exp_sum  (exp_sum),
    .exp_cout (exp_cout)
  );

`ifdef FA_BIST_FAULT_INJECT_EN
  logic inject_q;

  always_ff @(posedge clk) begin
    if (rst)         inject_q <= 1'b0;
    else if (accept) inject_q <= inject;
  end

  assign exp_sum_eff = exp_sum ^ (inject_q && (vec_q == 3'b101));
`else
  assign exp_sum_eff = exp_sum;
`endif

  assign mismatch = (dut.sum != exp_sum_eff) || (dut.cout != exp_cout);

  // Operands come straight from the vector register, so they are registered
  // and keep the last vector after a run.
  assign dut.a     = vec_q[2];
  assign dut.b     = vec_q[1];
  assign dut.cin   = vec_q[0];
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = APPLY;
      APPLY:   if (settle_done) state_d = CHECK;
      CHECK:   state_d = last_vec ? FINISH : APPLY;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    accept    = 1'b0;
    do_settle = 1'b0;
    do_check  = 1'b0;
    do_finish = 1'b0;
    case (state_q)
      IDLE:    accept    = start;
      APPLY:   do_settle = 1'b1;
      CHECK:   do_check  = 1'b1;
      FINISH:  do_finish = 1'b1;
      default: ;
    endcase
  end

  // done/busy/pass are registered: the FINISH cycle sets them on its closing edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      vec_q          <= '0;
      settle_q       <= '0;
      pass_cnt_q     <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_fail_vld <= 1'b0;
      first_fail_vec <= '0;
    end else begin
      done <= do_finish;
      if (accept) begin
        vec_q          <= '0;
        settle_q       <= '0;
        pass_cnt_q     <= '0;
        busy           <= 1'b1;
        pass           <= 1'b0;
        err_count      <= '0;
        first_fail_vld <= 1'b0;
        first_fail_vec <= '0;
      end
      if (do_settle) settle_q <= settle_done ? '0 : settle_q + SET_W'(1);
      if (do_check) begin
        if (mismatch) begin
          if (err_count != {ERR_W{1'b1}}) err_count <= err_count + ERR_W'(1);
          if (!first_fail_vld) begin
            first_fail_vld <= 1'b1;
            first_fail_vec <= vec_q;
          end
        end
        if (!last_vec) begin
          vec_q <= vec_q + VEC_W'(1);
          if (vec_q == LAST_VEC) pass_cnt_q <= pass_cnt_q + PAS_W'(1);
        end
      end
      if (do_finish) begin
        busy <= 1'b0;
        pass <= (err_count == '0);
      end
    end
  end

endmodule

// File: tb/tb_full_adder_bist.sv
// Bench for full_adder_bist: two instances (default and PASSES=3/SETTLE=2/ERR_W=2) against a faultable adder.
module tb_full_adder_bist;
  import fa_bist_pkg::*;

  localparam int P1 = 3;
  localparam int S1 = 2;
  localparam int E1 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start0, start1;
  full_adder_bist_if if0 ();
  full_adder_bist_if if1 ();

  logic busy0, done0, pass0, ffv0;
  logic [7:0] err0;
  logic [2:0] ffvec0;
  state_t st0;
  logic busy1, done1, pass1, ffv1;
  logic [E1-1:0] err1;
  logic [2:0] ffvec1;
  state_t st1;

  // Behavioural adder under test: arithmetic sum with a per-vector {cout,sum} flip table
  logic [1:0] fl0 [8];
  logic [1:0] fl1 [8];
  logic [1:0] r0, r1;
  assign r0 = (2'(if0.a) + 2'(if0.b) + 2'(if0.cin)) ^ fl0[{if0.a, if0.b, if0.cin}];
  assign r1 = (2'(if1.a) + 2'(if1.b) + 2'(if1.cin)) ^ fl1[{if1.a, if1.b, if1.cin}];
  assign if0.sum = r0[0];
  assign if0.cout = r0[1];
  assign if1.sum = r1[0];
  assign if1.cout = r1[1];

  full_adder_bist u_dut0 (
    .clk (clk), .rst (rst), .start (start0),
`ifdef FA_BIST_FAULT_INJECT_EN
    .inject (1'b0),
`endif
    .dut (if0.master), .busy (busy0), .done (done0), .pass (pass0), .err_count (err0),
    .first_fail_vld (ffv0), .first_fail_vec (ffvec0), .dbg_state (st0)
  );

  full_adder_bist #(.SETTLE_CYCLES(S1), .PASSES(P1), .ERR_W(E1)) u_dut1 (
    .clk (clk), .rst (rst), .start (start1),
`ifdef FA_BIST_FAULT_INJECT_EN
    .inject (1'b0),
`endif
    .dut (if1.master), .busy (busy1), .done (done1), .pass (pass1), .err_count (err1),
    .first_fail_vld (ffv1), .first_fail_vec (ffvec1), .dbg_state (st1)
  );

  int sel = 0;
  logic m_busy, m_done, m_pass, m_ffv;
  logic [2:0] m_vec, m_ffvec;
  logic [31:0] m_err;
  assign m_busy  = (sel != 0) ? busy1 : busy0;
  assign m_done  = (sel != 0) ? done1 : done0;
  assign m_pass  = (sel != 0) ? pass1 : pass0;
  assign m_ffv   = (sel != 0) ? ffv1 : ffv0;
  assign m_ffvec = (sel != 0) ? ffvec1 : ffvec0;
  assign m_vec   = (sel != 0) ? {if1.a, if1.b, if1.cin} : {if0.a, if0.b, if0.cin};
  assign m_err   = (sel != 0) ? 32'(err1) : 32'(err0);

  int passed = 0;
  int total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: every faulty vector miscompares once per sweep; counter saturates.
  function automatic void model(input logic [1:0] tbl [8], input int passes, input int errw,
                                output int cnt, output int first);
    int bad = 0;
    first = 0;
    for (int v = 7; v >= 0; v--) begin
      if (tbl[v] != 2'b00) begin
        bad++;
        first = v;
      end
    end
    cnt = bad * passes;
    if (cnt > (1 << errw) - 1) cnt = (1 << errw) - 1;
  endfunction

  task automatic set_start(input int s, input logic v);
    if (s != 0) start1 = v;
    else start0 = v;
  endtask

  task automatic clear_tbl(input int s);
    for (int v = 0; v < 8; v++) begin
      if (s != 0) fl1[v] = 2'b00;
      else fl0[v] = 2'b00;
    end
  endtask

  task automatic rand_tbl(input int s);
    logic [1:0] f;
    for (int v = 0; v < 8; v++) begin
      f = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if (s != 0) fl1[v] = f;
      else fl0[v] = f;
    end
  endtask

  task automatic run(input int s, input bit hold, input string tag);
    int passes, settle, errw, len, cnt, first, cyc, bad;
    logic [1:0] tbl [8];
    logic [2:0] seen [$];
    logic [2:0] exp_q [$];
    sel = s;
    passes = (s != 0) ? P1 : 1;
    settle = (s != 0) ? S1 : 1;
    errw = (s != 0) ? E1 : 8;
    for (int v = 0; v < 8; v++) tbl[v] = (s != 0) ? fl1[v] : fl0[v];
    model(tbl, passes, errw, cnt, first);
    len = 8 * passes * (settle + 1) + 1;
    for (int p = 0; p < passes; p++)
      for (int v = 0; v < 8; v++)
        for (int k = 0; k <= settle; k++) exp_q.push_back(3'(v));
    @(negedge clk);
    set_start(s, 1'b1);
    @(posedge clk);
    cyc = 0;
    while (cyc < 400) begin
      @(negedge clk);
      if (!hold) set_start(s, 1'b0);
      if (cyc == 0) check({tag, "_busy"}, 32'(m_busy), 32'd1);
      if (cyc < len - 1) seen.push_back(m_vec);
      if (m_done) break;
      @(posedge clk);
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(len));
    check({tag, "_err"}, m_err, 32'(cnt));
    check({tag, "_pass"}, 32'(m_pass), 32'(cnt == 0));
    check({tag, "_ffv"}, 32'(m_ffv), 32'(cnt != 0));
    check({tag, "_ffvec"}, 32'(m_ffvec), 32'(first));
    check({tag, "_busy_end"}, 32'(m_busy), 32'd0);
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= seen.size() || seen[i] !== exp_q[i]) bad++;
    check({tag, "_vec_seq"}, 32'(bad), 32'd0);
    if (!hold) begin
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(m_done), 32'd0);
    end
  endtask

  int k, dones;

  initial begin
    rst = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    clear_tbl(0);
    clear_tbl(1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outs0", {busy0, done0, pass0, ffv0, ffvec0, err0}, 32'd0);
    check("rst_outs1", {busy1, done1, pass1, ffv1, ffvec1, err1}, 32'd0);
    check("rst_vec0", 32'({if0.a, if0.b, if0.cin}), 32'd0);
    check("rst_state0", 32'(st0), 32'(IDLE));
    check("rst_state1", 32'(st1), 32'(IDLE));
    rst = 1'b0;

    run(0, 1'b0, "good");
    check("good_vec_after", 32'(m_vec), 32'd7);

    // Cout stuck-at-0: flip cout wherever the true carry is 1
    for (int v = 0; v < 8; v++) begin
      logic [2:0] vv;
      vv = 3'(v);
      fl0[v] = {((32'(vv[2]) + 32'(vv[1]) + 32'(vv[0])) >= 2), 1'b0};
    end
    run(0, 1'b0, "cout_sa0");
    check("cout_sa0_err4", m_err, 32'd4);
    check("cout_sa0_first011", 32'(m_ffvec), 32'b011);

    // start held high: second run accepted right after done and clears the results
    run(0, 1'b1, "hold");
    @(posedge clk);
    @(negedge clk);
    check("hold_rerun_busy", 32'(m_busy), 32'd1);
    check("hold_rerun_err_clr", m_err, 32'd0);
    check("hold_rerun_vec", 32'(m_vec), 32'd0);
    start0 = 1'b0;
    k = 0;
    while (!m_done && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("hold_rerun_done", 32'(m_done), 32'd1);
    check("hold_rerun_err", m_err, 32'd4);

    // Reset while vector 4 is being applied
    clear_tbl(0);
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    k = 0;
    while (m_vec != 3'd4 && k < 60) begin
      @(negedge clk);
      k++;
    end
    check("abort_reach_vec4", 32'(m_vec), 32'd4);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_outs", {busy0, done0, pass0, ffv0, ffvec0, err0}, 32'd0);
    check("abort_vec", 32'(m_vec), 32'd0);
    check("abort_state", 32'(st0), 32'(IDLE));
    rst = 1'b0;
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (done0) dones++;
    end
    check("abort_no_done", 32'(dones), 32'd0);
    run(0, 1'b0, "after_abort");

    for (int i = 0; i < 6; i++) begin
      rand_tbl(0);
      run(0, 1'b0, "rand0");
    end

    // Second instance: Sum stuck-at-1 over 3 sweeps, 2-bit counter saturates
    for (int v = 0; v < 8; v++) begin
      logic [2:0] vv;
      vv = 3'(v);
      fl1[v] = {1'b0, ((32'(vv[2]) + 32'(vv[1]) + 32'(vv[0])) % 2) == 0};
    end
    run(1, 1'b0, "sum_sa1");
    check("sum_sa1_sat", m_err, 32'd3);
    check("sum_sa1_first000", 32'(m_ffvec), 32'b000);
    clear_tbl(1);
    run(1, 1'b0, "good1");
    for (int i = 0; i < 3; i++) begin
      rand_tbl(1);
      run(1, 1'b0, "rand1");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
